mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the picorv32 native memory bus, peer slave of verilog_ram.

---
 rtl/mmio_uart_tx_pkg.sv | 35 +++
 rtl/mmio_uart_tx_if.sv | 30 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 60 ++++++
 rtl/mmio_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS layout and TX FSM encoding.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_CNT   = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [31:0] status_word(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic [7:0] count
    );
        logic [31:0] w;
        w = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_CNT +: 8] = count;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// picorv32 native memory bus as seen by one peer slave.
// The CPU side is the master; the UART is a slave.
interface mmio_uart_tx_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 bus:
// bus decode and ack register, TX FIFO, baud counter and serialiser.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    mmio_uart_tx_if.slave        bus,
    output logic                 uart_tx,
    output logic                 irq_tx_empty
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

    logic          ready_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rdata_d;
    logic          win_hit;
    logic          hit;
    logic          is_write;
    logic [1:0]    reg_sel;
    logic          push_req;
    logic          stall;
    logic          ack_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count8;

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic [15:0]   baud_q;
    logic [15:0]   baud_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [7:0]    shreg_q;
    logic [7:0]    shreg_d;
    logic          tx_q;
    logic          tx_d;
    logic          irq_q;
    logic          busy;

    logic          unused_bits;
    assign unused_bits = ^{bus.mem_wdata[31:8], bus.mem_addr[1:0]};

    // A pending ack blocks re-acceptance while the CPU drops mem_valid.
    assign win_hit  = bus.mem_valid
                   && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign hit      = win_hit && !ready_q;
    assign is_write = |bus.mem_wstrb;
    assign reg_sel  = bus.mem_addr[3:2];
    assign push_req = hit && (reg_sel == REG_TXDATA)
                   && bus.mem_wstrb[0];
    assign stall     = push_req && fifo_full;
    assign fifo_push = push_req && !fifo_full;
    assign ack_d     = hit && !stall;

    assign busy   = (state_q != TX_IDLE);
    assign count8 = 8'(fifo_count);

    always_comb begin
        rdata_d = '0;
        if (hit && !is_write && (reg_sel == REG_STATUS)) begin
            rdata_d = status_word(busy, fifo_full,
                                  fifo_empty, count8);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ack_d;
            rdata_q <= ack_d ? rdata_d : '0;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .wdata  (bus.mem_wdata[7:0]),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // tx_d is the level for the next cycle, so uart_tx comes
    // straight from a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    baud_d   = BAUD_LOAD;
                    tx_d     = 1'b0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (baud_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            irq_q   <= fifo_empty && (state_q == TX_IDLE);
        end
    end

    assign uart_tx      = tx_q;
    assign irq_tx_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4):
// bus accesses through the interface, serial line decoded by a monitor.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TXD  = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_R8   = 32'h1000_0008;
    localparam logic [31:0] A_MISS = 32'h2000_0000;

    logic clk = 1'b0;
    logic resetn;
    logic uart_tx;
    logic irq_tx_empty;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR  (32'h1000_0000),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .uart_tx      (uart_tx),
        .irq_tx_empty (irq_tx_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q [$];
    int         st_q [$];
    bit         ok_q [$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where mem_ready
    // is seen (lat = negedges waited) or lat = 0 on timeout.
    task automatic xfer(input  logic [31:0] addr,
                        input  logic [31:0] wdata,
                        input  logic [3:0]  wstrb,
                        input  int          budget,
                        output int          lat,
                        output logic [31:0] rdata);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat   = 0;
        rdata = '0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat   = i;
                rdata = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        check("frame_wait", rx_q.size(), n);
    endtask

    task automatic check_frame(input int idx, input logic [7:0] b);
        if (idx < rx_q.size()) begin
            check("frame_byte", rx_q[idx], b);
            check("frame_shape", ok_q[idx], 1);
        end else begin
            check("frame_missing", rx_q.size(), idx + 1);
        end
    endtask

    task automatic check_gap(input int idx, input int gap);
        if (idx < st_q.size()) begin
            check("frame_gap", st_q[idx] - st_q[idx-1], gap);
        end else begin
            check("gap_missing", st_q.size(), idx + 1);
        end
    endtask

    // Serial monitor: 40 samples per frame, one per clock.
    initial begin : monitor
        logic [39:0] smp;
        int          st;
        bit          abort;
        bit          ok;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                st    = cyc;
                smp   = '0;
                abort = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (resetn !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    smp[i] = uart_tx;
                end
                if (!abort) begin
                    ok = (smp[3:0] == 4'h0)
                      && (smp[39:36] == 4'hF);
                    for (int k = 0; k < 8; k++) begin
                        b[k] = smp[4 + 4*k];
                        if (smp[4 + 4*k +: 4] != {4{b[k]}})
                            ok = 1'b0;
                    end
                    rx_q.push_back(b);
                    st_q.push_back(st);
                    ok_q.push_back(ok);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int          lat;
        int          lats [6];
        logic [31:0] rd;
        int          base;
        int          ack_cyc;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'h0;
        resetn        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_ready", bus.mem_ready, 0);
        check("rst_rdata", bus.mem_rdata, 0);
        check("rst_irq", irq_tx_empty, 1);
        resetn = 1'b1;
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("rst_status", rd, 32'h0000_0004);
        check("rst_status_lat", lat, 1);

        // Single frame 0x55
        idle(5);
        base = rx_q.size();
        xfer(A_TXD, 32'h55, 4'h1, 200, lat, rd);
        check("wr55_lat", lat, 1);
        ack_cyc = cyc;
        repeat (41) @(negedge clk);
        check("irq_busy", irq_tx_empty, 0);
        @(negedge clk);
        check("irq_done", irq_tx_empty, 1);
        check("f55_count", rx_q.size(), base + 1);
        check_frame(base, 8'h55);
        if (base < st_q.size())
            check("f55_start", st_q[base] - ack_cyc, 1);
        else
            check("f55_nostart", st_q.size(), base + 1);

        // Six back-to-back writes into a 4-deep FIFO
        idle(5);
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            xfer(A_TXD, 32'hA1 + i, 4'h1, 200, lats[i], rd);
        end
        check("bb_lat0", lats[0], 1);
        for (int i = 1; i < 5; i++) check("bb_lat", lats[i], 2);
        check("bb_lat5_stall", lats[5], 35);
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("bb_status_full", rd, 32'h0000_0403);
        wait_frames(base + 6);
        for (int i = 0; i < 6; i++) check_frame(base + i, 8'hA1 + i);
        for (int i = 1; i < 6; i++) check_gap(base + i, 41);

        // STATUS mid-frame, ignored writes, zero reads
        idle(5);
        base = rx_q.size();
        xfer(A_TXD, 32'h11, 4'h1, 200, lat, rd);
        xfer(A_TXD, 32'h22, 4'h1, 200, lat, rd);
        xfer(A_TXD, 32'h33, 4'h1, 200, lat, rd);
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("mid_status", rd, 32'h0000_0201);
        @(negedge clk);
        check("rdata_clear", bus.mem_rdata, 0);
        check("ready_clear", bus.mem_ready, 0);
        xfer(A_STAT, 32'hFFFF_FFFF, 4'hF, 200, lat, rd);
        check("stat_wr_lat", lat, 1);
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("stat_after_wr", rd, 32'h0000_0201);
        xfer(A_TXD, 0, 4'h0, 200, lat, rd);
        check("txd_read", rd, 0);
        xfer(A_R8, 0, 4'h0, 200, lat, rd);
        check("r8_read", rd, 0);
        check("r8_acked", lat != 0, 1);
        wait_frames(base + 3);
        check_frame(base, 8'h11);
        check_frame(base + 1, 8'h22);
        check_frame(base + 2, 8'h33);
        check_gap(base + 1, 41);
        check_gap(base + 2, 41);

        // No lane-0 strobe, and misses
        idle(5);
        base = rx_q.size();
        xfer(A_TXD, 32'h99, 4'b0010, 200, lat, rd);
        check("nostrb_lat", lat, 1);
        xfer(A_MISS, 0, 4'h0, 10, lat, rd);
        check("miss_rd_ack", lat, 0);
        xfer(A_MISS, 32'h77, 4'hF, 10, lat, rd);
        check("miss_wr_ack", lat, 0);
        check("miss_rdata", bus.mem_rdata, 0);
        repeat (60) @(negedge clk);
        check("nostrb_frames", rx_q.size(), base);
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("nostrb_status", rd, 32'h0000_0004);

        // Reset during DATA bit 3
        idle(5);
        base = rx_q.size();
        xfer(A_TXD, 32'hF0, 4'h1, 200, lat, rd);
        xfer(A_TXD, 32'h0F, 4'h1, 200, lat, rd);
        repeat (16) @(negedge clk);
        check("bit3_low", uart_tx, 0);
        resetn = 1'b0;
        #1;
        check("rst_mid_tx", uart_tx, 1);
        check("rst_mid_irq", irq_tx_empty, 1);
        check("rst_mid_ready", bus.mem_ready, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        xfer(A_STAT, 0, 4'h0, 200, lat, rd);
        check("rst_mid_status", rd, 32'h0000_0004);
        repeat (60) @(negedge clk);
        check("rst_mid_frames", rx_q.size(), base);
        check("rst_mid_idle", uart_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
